// File: rtl/dma_pkg.sv
// Shared types for the DMA channel scheduler: completion status, FSM states
// and AXI response codes.
package dma_pkg;

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_ZERO_LEN = 2'b01,
        ST_BUS_ERR  = 2'b10,
        ST_TIMEOUT  = 2'b11
    } dma_status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_ABORT,
        S_CPL
    } sched_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic dma_status_e resp_status(input logic [1:0] r);
        return (r == RESP_OKAY || r == RESP_EXOKAY) ? ST_OK : ST_BUS_ERR;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr_i,
// wrapping to 0; returns one-hot grant plus its index.
module rr_arbiter #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);

    always_comb begin
        int t;
        logic [W-1:0] j;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        t       = 0;
        j       = '0;
        for (int i = 0; i < N; i++) begin
            t = int'(ptr_i) + i;
            if (t >= N) t = t - N;
            j = W'(t);
            if (!valid_o && req_i[j]) begin
                valid_o  = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end

endmodule

// File: rtl/dma_channel_scheduler.sv
// Round-robin scheduler sharing one DMA master command port among NUM_CH
// channels, with one transfer in flight and a BUSY-state watchdog.
module dma_channel_scheduler
    import dma_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int AXI_ADDR_W     = 32,
    parameter int LEN_W          = 24,
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int CH_W          = $clog2(NUM_CH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          ch_en_i,
    input  logic [NUM_CH-1:0]          ch_req_valid_i,
    output logic [NUM_CH-1:0]          ch_req_ready_o,
    input  logic [NUM_CH*AXI_ADDR_W-1:0] ch_src_addr_i,
    input  logic [NUM_CH*AXI_ADDR_W-1:0] ch_dst_addr_i,
    input  logic [NUM_CH*LEN_W-1:0]    ch_len_i,
    output logic                       cpl_valid_o,
    output logic [CH_W-1:0]            cpl_ch_o,
    output logic [1:0]                 cpl_status_o,
    output logic                       dma_cmd_valid_o,
    input  logic                       dma_cmd_ready_i,
    output logic [AXI_ADDR_W-1:0]      dma_cmd_src_o,
    output logic [AXI_ADDR_W-1:0]      dma_cmd_dst_o,
    output logic [LEN_W-1:0]           dma_cmd_len_o,
    input  logic                       dma_done_i,
    input  logic [1:0]                 dma_resp_i,
    output logic                       dma_abort_o,
    input  logic                       dma_idle_i,
    output logic                       busy_o,
    output logic [CH_W-1:0]            active_ch_o
);

    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    localparam int WD_W  = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_EXP = WD_EN ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

    sched_state_e          state_q;
    dma_status_e           cpl_status_q;
    logic                  cpl_valid_q;
    logic                  cmd_valid_q;
    logic                  abort_q;
    logic [CH_W-1:0]       active_ch_q;
    logic [CH_W-1:0]       rr_ptr_q;
    logic [CH_W-1:0]       rr_ptr_d;
    logic [WD_W-1:0]       wd_q;
    logic [WD_W-1:0]       wd_d;
    logic [AXI_ADDR_W-1:0] src_q;
    logic [AXI_ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]      len_q;

    logic [NUM_CH-1:0]     elig;
    logic [NUM_CH-1:0]     gnt;
    logic [CH_W-1:0]       gidx;
    logic                  gvalid;
    logic [AXI_ADDR_W-1:0] sel_src;
    logic [AXI_ADDR_W-1:0] sel_dst;
    logic [LEN_W-1:0]      sel_len;

    assign elig = ch_req_valid_i & ch_en_i;

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .req_i   (elig),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (gnt),
        .idx_o   (gidx),
        .valid_o (gvalid)
    );

    always_comb begin
        sel_src = '0;
        sel_dst = '0;
        sel_len = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gidx == CH_W'(i)) begin
                sel_src = ch_src_addr_i[i*AXI_ADDR_W +: AXI_ADDR_W];
                sel_dst = ch_dst_addr_i[i*AXI_ADDR_W +: AXI_ADDR_W];
                sel_len = ch_len_i[i*LEN_W +: LEN_W];
            end
        end
    end

    assign rr_ptr_d = (gidx == CH_W'(NUM_CH - 1)) ? '0 : gidx + 1'b1;
    assign wd_d     = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;

    // The accept pulse is the grant itself; masked while reset is held.
    assign ch_req_ready_o = (rst_n && state_q == S_IDLE) ? gnt : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cpl_status_q <= ST_OK;
            cpl_valid_q  <= 1'b0;
            cmd_valid_q  <= 1'b0;
            abort_q      <= 1'b0;
            active_ch_q  <= '0;
            rr_ptr_q     <= '0;
            wd_q         <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
        end else begin
            cpl_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (gvalid) begin
                        active_ch_q <= gidx;
                        rr_ptr_q    <= rr_ptr_d;
                        src_q       <= sel_src;
                        dst_q       <= sel_dst;
                        len_q       <= sel_len;
                        cmd_valid_q <= (sel_len != '0);
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (len_q == '0) begin
                        cpl_status_q <= ST_ZERO_LEN;
                        cpl_valid_q  <= 1'b1;
                        state_q      <= S_CPL;
                    end else if (dma_cmd_ready_i) begin
                        cmd_valid_q <= 1'b0;
                        wd_q        <= '0;
                        state_q     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Completion in the expiry cycle beats the watchdog.
                    if (dma_done_i) begin
                        cpl_status_q <= resp_status(dma_resp_i);
                        cpl_valid_q  <= 1'b1;
                        state_q      <= S_CPL;
                    end else if (WD_EN && wd_q == WD_EXP) begin
                        abort_q <= 1'b1;
                        state_q <= S_ABORT;
                    end else begin
                        wd_q <= wd_d;
                    end
                end
                S_ABORT: begin
                    if (dma_idle_i) begin
                        abort_q      <= 1'b0;
                        cpl_status_q <= ST_TIMEOUT;
                        cpl_valid_q  <= 1'b1;
                        state_q      <= S_CPL;
                    end
                end
                S_CPL: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cpl_valid_o     = cpl_valid_q;
    assign cpl_ch_o        = active_ch_q;
    assign cpl_status_o    = cpl_status_q;
    assign dma_cmd_valid_o = cmd_valid_q;
    assign dma_cmd_src_o   = src_q;
    assign dma_cmd_dst_o   = dst_q;
    assign dma_cmd_len_o   = len_q;
    assign dma_abort_o     = abort_q;
    assign busy_o          = (state_q != S_IDLE);
    assign active_ch_o     = active_ch_q;

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Directed bench for dma_channel_scheduler: arbitration table plus
// hand-written zero-length, watchdog, expiry and reset sequences.
module tb_dma_channel_scheduler;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 24;
    localparam int TO = 24;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    ch_en_i;
    logic [N-1:0]    ch_req_valid_i;
    logic [N-1:0]    ch_req_ready_o;
    logic [N*AW-1:0] ch_src_addr_i;
    logic [N*AW-1:0] ch_dst_addr_i;
    logic [N*LW-1:0] ch_len_i;
    logic            cpl_valid_o;
    logic [1:0]      cpl_ch_o;
    logic [1:0]      cpl_status_o;
    logic            dma_cmd_valid_o;
    logic            dma_cmd_ready_i;
    logic [AW-1:0]   dma_cmd_src_o;
    logic [AW-1:0]   dma_cmd_dst_o;
    logic [LW-1:0]   dma_cmd_len_o;
    logic            dma_done_i;
    logic [1:0]      dma_resp_i;
    logic            dma_abort_o;
    logic            dma_idle_i;
    logic            busy_o;
    logic [1:0]      active_ch_o;

    always #5 clk = ~clk;

    dma_channel_scheduler #(
        .NUM_CH(N), .AXI_ADDR_W(AW), .LEN_W(LW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ch_en_i(ch_en_i), .ch_req_valid_i(ch_req_valid_i),
        .ch_req_ready_o(ch_req_ready_o),
        .ch_src_addr_i(ch_src_addr_i), .ch_dst_addr_i(ch_dst_addr_i),
        .ch_len_i(ch_len_i),
        .cpl_valid_o(cpl_valid_o), .cpl_ch_o(cpl_ch_o),
        .cpl_status_o(cpl_status_o),
        .dma_cmd_valid_o(dma_cmd_valid_o), .dma_cmd_ready_i(dma_cmd_ready_i),
        .dma_cmd_src_o(dma_cmd_src_o), .dma_cmd_dst_o(dma_cmd_dst_o),
        .dma_cmd_len_o(dma_cmd_len_o),
        .dma_done_i(dma_done_i), .dma_resp_i(dma_resp_i),
        .dma_abort_o(dma_abort_o), .dma_idle_i(dma_idle_i),
        .busy_o(busy_o), .active_ch_o(active_ch_o)
    );

    int total = 0;
    int bad   = 0;
    logic [LW-1:0] lens [N];

    typedef struct {
        logic [3:0] en;
        logic [3:0] v;
        int         g;
        logic [1:0] resp;
        logic [1:0] st;
    } vec_t;

    vec_t tbl [11];

    function automatic logic [AW-1:0] exp_src(input int c);
        return 32'h1000_0000 + 32'(c) * 32'h100;
    endfunction

    function automatic logic [AW-1:0] exp_dst(input int c);
        return 32'h2000_0000 + 32'(c) * 32'h40;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_desc();
        for (int c = 0; c < N; c++) begin
            ch_src_addr_i[c*AW +: AW] = exp_src(c);
            ch_dst_addr_i[c*AW +: AW] = exp_dst(c);
            ch_len_i[c*LW +: LW]      = lens[c];
        end
    endtask

    task automatic xfer(input logic [3:0] en, input logic [3:0] v,
                        input int eg, input logic [1:0] resp,
                        input int gap, input logic [1:0] est,
                        input string tag);
        bit seen;
        bit ab;
        int g;
        seen = 1'b0;
        ab   = 1'b0;
        @(negedge clk);
        ch_en_i        = en;
        ch_req_valid_i = v;
        #1;
        for (int i = 0; i < 8; i++) begin
            if (ch_req_ready_o != '0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (eg < 0) begin
            chk({tag, " nogrant"}, 32'(seen), 32'd0);
            ch_req_valid_i = '0;
            return;
        end
        g = eg;
        chk({tag, " grant"}, 32'(ch_req_ready_o), 32'(1) << g);
        if (!seen) begin
            ch_req_valid_i = '0;
            return;
        end
        @(negedge clk);
        dma_cmd_ready_i = 1'b1;
        #1;
        chk({tag, " ready pulse"}, 32'(ch_req_ready_o), 32'd0);
        chk({tag, " cmd_valid"}, 32'(dma_cmd_valid_o), 32'd1);
        chk({tag, " src"}, dma_cmd_src_o, exp_src(g));
        chk({tag, " dst"}, dma_cmd_dst_o, exp_dst(g));
        chk({tag, " len"}, 32'(dma_cmd_len_o), 32'(lens[g]));
        chk({tag, " active"}, 32'(active_ch_o), 32'(g));
        @(negedge clk);
        dma_cmd_ready_i = 1'b0;
        ch_req_valid_i  = '0;
        #1;
        chk({tag, " cmd drop"}, 32'(dma_cmd_valid_o), 32'd0);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            #1;
            ab |= dma_abort_o;
        end
        dma_done_i = 1'b1;
        dma_resp_i = resp;
        @(negedge clk);
        dma_done_i = 1'b0;
        #1;
        ab |= dma_abort_o;
        chk({tag, " cpl_valid"}, 32'(cpl_valid_o), 32'd1);
        chk({tag, " cpl_ch"}, 32'(cpl_ch_o), 32'(g));
        chk({tag, " status"}, 32'(cpl_status_o), 32'(est));
        chk({tag, " noabort"}, 32'(ab), 32'd0);
        @(negedge clk);
        #1;
        chk({tag, " cpl end"}, 32'(cpl_valid_o), 32'd0);
        chk({tag, " idle"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int acyc;
        bit cpl_seen;
        rst_n           = 1'b0;
        ch_en_i         = '1;
        ch_req_valid_i  = '1;
        dma_cmd_ready_i = 1'b0;
        dma_done_i      = 1'b0;
        dma_resp_i      = 2'b00;
        dma_idle_i      = 1'b0;
        for (int c = 0; c < N; c++) lens[c] = 24'h100 + 24'(c) * 24'h10;
        load_desc();

        tbl[0]  = '{4'hF, 4'hF, 0,  2'b00, 2'b00};
        tbl[1]  = '{4'hF, 4'hF, 1,  2'b01, 2'b00};
        tbl[2]  = '{4'hF, 4'hF, 2,  2'b10, 2'b10};
        tbl[3]  = '{4'hF, 4'hF, 3,  2'b11, 2'b10};
        tbl[4]  = '{4'hF, 4'hF, 0,  2'b00, 2'b00};
        tbl[5]  = '{4'hB, 4'hC, 3,  2'b00, 2'b00};
        tbl[6]  = '{4'hF, 4'h4, 2,  2'b00, 2'b00};
        tbl[7]  = '{4'hF, 4'h3, 0,  2'b00, 2'b00};
        tbl[8]  = '{4'hE, 4'h1, -1, 2'b00, 2'b00};
        tbl[9]  = '{4'hF, 4'h1, 0,  2'b00, 2'b00};
        tbl[10] = '{4'hF, 4'h9, 3,  2'b00, 2'b00};

        repeat (2) @(negedge clk);
        #1;
        chk("rst ready", 32'(ch_req_ready_o), 32'd0);
        chk("rst busy", 32'(busy_o), 32'd0);
        chk("rst cmd_valid", 32'(dma_cmd_valid_o), 32'd0);
        chk("rst cpl_valid", 32'(cpl_valid_o), 32'd0);
        chk("rst abort", 32'(dma_abort_o), 32'd0);
        chk("rst active", 32'(active_ch_o), 32'd0);
        chk("rst src", dma_cmd_src_o, 32'd0);
        @(negedge clk);
        rst_n          = 1'b1;
        ch_req_valid_i = '0;

        foreach (tbl[k])
            xfer(tbl[k].en, tbl[k].v, tbl[k].g, tbl[k].resp, 3,
                 tbl[k].st, $sformatf("vec%0d", k));

        xfer(4'hF, 4'h2, 1, 2'b00, 19, 2'b00, "ch1 basic");

        lens[0] = '0;
        load_desc();
        @(negedge clk);
        ch_req_valid_i = 4'h1;
        #1;
        chk("zl grant", 32'(ch_req_ready_o), 32'h1);
        @(negedge clk);
        ch_req_valid_i = '0;
        #1;
        chk("zl no cmd", 32'(dma_cmd_valid_o), 32'd0);
        chk("zl busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        #1;
        chk("zl cpl_valid", 32'(cpl_valid_o), 32'd1);
        chk("zl status", 32'(cpl_status_o), 32'd1);
        chk("zl cpl_ch", 32'(cpl_ch_o), 32'd0);
        chk("zl no cmd2", 32'(dma_cmd_valid_o), 32'd0);
        @(negedge clk);
        #1;
        chk("zl cpl end", 32'(cpl_valid_o), 32'd0);
        lens[0] = 24'h100;
        load_desc();

        @(negedge clk);
        ch_req_valid_i = 4'h4;
        #1;
        chk("wd grant", 32'(ch_req_ready_o), 32'h4);
        @(negedge clk);
        dma_cmd_ready_i = 1'b1;
        ch_req_valid_i  = '0;
        #1;
        chk("wd cmd_valid", 32'(dma_cmd_valid_o), 32'd1);
        acyc = 0;
        for (int i = 1; i <= TO + 8; i++) begin
            @(negedge clk);
            dma_cmd_ready_i = 1'b0;
            #1;
            if (dma_abort_o) begin
                acyc = i;
                break;
            end
        end
        chk("wd abort cycle", 32'(acyc), 32'(TO + 1));
        dma_done_i = 1'b1;
        dma_resp_i = 2'b00;
        cpl_seen   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dma_done_i = 1'b0;
            #1;
            cpl_seen |= cpl_valid_o;
            chk($sformatf("wd abort hold%0d", i), 32'(dma_abort_o), 32'd1);
        end
        chk("wd done ignored", 32'(cpl_seen), 32'd0);
        @(negedge clk);
        dma_idle_i = 1'b1;
        @(negedge clk);
        dma_idle_i = 1'b0;
        #1;
        chk("wd cpl_valid", 32'(cpl_valid_o), 32'd1);
        chk("wd status", 32'(cpl_status_o), 32'd3);
        chk("wd cpl_ch", 32'(cpl_ch_o), 32'd2);
        chk("wd abort drop", 32'(dma_abort_o), 32'd0);
        @(negedge clk);
        #1;
        chk("wd idle", 32'(busy_o), 32'd0);

        xfer(4'hF, 4'h8, 3, 2'b00, TO - 1, 2'b00, "expiry done");

        @(negedge clk);
        ch_req_valid_i = 4'hF;
        #1;
        chk("mr grant", 32'(ch_req_ready_o), 32'h1);
        @(negedge clk);
        dma_cmd_ready_i = 1'b1;
        @(negedge clk);
        dma_cmd_ready_i = 1'b0;
        #1;
        chk("mr busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("mr rst busy", 32'(busy_o), 32'd0);
        chk("mr rst cmd", 32'(dma_cmd_valid_o), 32'd0);
        chk("mr rst len", 32'(dma_cmd_len_o), 32'd0);
        chk("mr rst ready", 32'(ch_req_ready_o), 32'd0);
        chk("mr rst active", 32'(active_ch_o), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("mr regrant ch0", 32'(ch_req_ready_o), 32'h1);
        @(negedge clk);
        ch_req_valid_i = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
